change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 26 ++
 rtl/change_dispenser_coin_picker.sv | 27 ++
 rtl/change_dispenser.sv | 88 ++++++++
 tb/tb_change_dispenser.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared vending machine definitions: amount width, coin denominations and FSM state encoding.
package change_dispenser_pkg;

    localparam int TOTAL_BITS = 31;
    localparam int NUM_COINS  = 3;

    localparam int unsigned COIN_VAL_0 = 100;
    localparam int unsigned COIN_VAL_1 = 500;
    localparam int unsigned COIN_VAL_2 = 1000;
    localparam int unsigned MIN_COIN   = COIN_VAL_0;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DISPENSE = 2'd1;
    localparam logic [1:0] ST_DONE     = 2'd2;

    // Denominations are listed in ascending order; unknown indices never match.
    function automatic int unsigned coin_value(input int idx);
        case (idx)
            0:       return COIN_VAL_0;
            1:       return COIN_VAL_1;
            2:       return COIN_VAL_2;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_coin_picker.sv
// Combinational picker: largest denomination not exceeding the remaining amount.
module change_coin_picker
    import change_dispenser_pkg::*;
#(
    parameter int kTotalBits = TOTAL_BITS,
    parameter int kNumCoins  = NUM_COINS
) (
    input  logic [kTotalBits-1:0] remaining,
    output logic [kNumCoins-1:0]  sel,
    output logic [kTotalBits-1:0] value
);

    // Ascending scan, so the last match wins and is the largest coin.
    always_comb begin
        sel   = '0;
        value = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if ({1'b0, remaining} >= {1'b0, kTotalBits'(coin_value(i))} &&
                coin_value(i) != 32'hFFFF_FFFF) begin
                sel    = '0;
                sel[i] = 1'b1;
                value  = kTotalBits'(coin_value(i));
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out a requested amount one coin per handshake, largest coin first.
// Optional CHANGE_DISPENSER_STATS_EN adds o_total_dispensed, a running sum of dispensed coins.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int kTotalBits = TOTAL_BITS,
    parameter int kNumCoins  = NUM_COINS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_return_req,
    input  logic [kTotalBits-1:0] i_return_amount,
    output logic                  o_coin_valid,
    output logic [kNumCoins-1:0]  o_coin_sel,
    input  logic                  i_coin_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [kTotalBits-1:0] o_remaining
`ifdef CHANGE_DISPENSER_STATS_EN
    ,
    output logic [kTotalBits-1:0] o_total_dispensed
`endif
);

    localparam logic [kTotalBits-1:0] MinCoin = kTotalBits'(MIN_COIN);

    logic [1:0]            state;
    logic [kTotalBits-1:0] remaining;
    logic [kNumCoins-1:0]  pick_sel;
    logic [kTotalBits-1:0] coin_val;
    logic [kTotalBits-1:0] next_rem;
    logic                  handshake;

    change_coin_picker #(
        .kTotalBits(kTotalBits),
        .kNumCoins (kNumCoins)
    ) u_picker (
        .remaining(remaining),
        .sel      (pick_sel),
        .value    (coin_val)
    );

    // DISPENSE is only entered with remaining >= smallest coin, so this never wraps.
    assign next_rem  = remaining - coin_val;
    assign handshake = o_coin_valid & i_coin_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_return_req) begin
                        remaining <= i_return_amount;
                        state     <= (i_return_amount >= MinCoin) ? ST_DISPENSE : ST_DONE;
                    end
                end
                ST_DISPENSE: begin
                    if (i_coin_ready) begin
                        remaining <= next_rem;
                        if (next_rem < MinCoin) state <= ST_DONE;
                    end
                end
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    assign o_coin_valid = (state == ST_DISPENSE);
    assign o_coin_sel   = o_coin_valid ? pick_sel : '0;
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE);
    assign o_remaining  = remaining;

`ifdef CHANGE_DISPENSER_STATS_EN
    logic [kTotalBits-1:0] total;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       total <= '0;
        else if (handshake) total <= total + coin_val;
    end

    assign o_total_dispensed = total;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed scenarios plus randomized returns vs a model.
module tb_change_dispenser;

    logic        clk;
    logic        reset_n;
    logic        i_return_req;
    logic [30:0] i_return_amount;
    logic        o_coin_valid;
    logic [2:0]  o_coin_sel;
    logic        i_coin_ready;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_remaining;
`ifdef CHANGE_DISPENSER_STATS_EN
    logic [30:0] o_total_dispensed;
`endif

    int tests;
    int fails;

    change_dispenser dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_return_req   (i_return_req),
        .i_return_amount(i_return_amount),
        .o_coin_valid   (o_coin_valid),
        .o_coin_sel     (o_coin_sel),
        .i_coin_ready   (i_coin_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_remaining    (o_remaining)
`ifdef CHANGE_DISPENSER_STATS_EN
        ,
        .o_total_dispensed(o_total_dispensed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a one-cycle request; returns just after the accepting edge.
    task automatic send_req(input int unsigned amt);
        i_return_req    = 1'b1;
        i_return_amount = 31'(amt);
        step();
        i_return_req    = 1'b0;
    endtask

    function automatic logic [2:0] sel_of(input int unsigned coin);
        case (coin)
            1000:    return 3'b100;
            500:     return 3'b010;
            100:     return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0; i_return_req = 1'b0; i_return_amount = '0; i_coin_ready = 1'b0;
        #2;
        tests++;
        if ({o_coin_valid, o_coin_sel, o_busy, o_done, o_remaining} !== 37'd0) begin
            fails++;
            $display("FAIL reset_async: got valid=%b sel=%b busy=%b done=%b rem=%0d, expected all zero",
                     o_coin_valid, o_coin_sel, o_busy, o_done, o_remaining);
        end
        step(); step();
        reset_n = 1'b1;
        tests++;
        if (o_busy !== 1'b0 || o_remaining !== 31'd0) begin
            fails++;
            $display("FAIL reset_idle: got busy=%b rem=%0d, expected 0 0", o_busy, o_remaining);
        end
    endtask

    task automatic test_1600();
        logic [2:0] exp_sel [3];
        exp_sel[0] = 3'b100; exp_sel[1] = 3'b010; exp_sel[2] = 3'b001;
        i_coin_ready = 1'b1;
        send_req(1600);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({o_coin_valid, o_coin_sel, o_busy, o_done} !== {1'b1, exp_sel[k], 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL r1600_coin%0d: got valid=%b sel=%b busy=%b done=%b, expected 1 %b 1 0",
                         k, o_coin_valid, o_coin_sel, o_busy, o_done, exp_sel[k]);
            end
            step();
        end
        tests++;
        if ({o_coin_valid, o_coin_sel, o_done} !== 5'b0_000_1 || o_remaining !== 31'd0) begin
            fails++;
            $display("FAIL r1600_done: got valid=%b sel=%b done=%b rem=%0d, expected 0 000 1 0",
                     o_coin_valid, o_coin_sel, o_done, o_remaining);
        end
        step();
        tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL r1600_idle: got done=%b busy=%b, expected 0 0", o_done, o_busy);
        end
    endtask

    task automatic test_zero();
        i_coin_ready = 1'b1;
        send_req(0);
        tests++;
        if ({o_coin_valid, o_done, o_busy} !== 3'b011 || o_remaining !== 31'd0) begin
            fails++;
            $display("FAIL zero_done: got valid=%b done=%b busy=%b rem=%0d, expected 0 1 1 0",
                     o_coin_valid, o_done, o_busy, o_remaining);
        end
        step();
        tests++;
        if ({o_coin_valid, o_done, o_busy} !== 3'b000) begin
            fails++;
            $display("FAIL zero_idle: got valid=%b done=%b busy=%b, expected 0 0 0",
                     o_coin_valid, o_done, o_busy);
        end
    endtask

    task automatic test_stall_500();
        i_coin_ready = 1'b0;
        send_req(500);
        for (int k = 0; k < 5; k++) begin
            tests++;
            if ({o_coin_valid, o_coin_sel} !== 4'b1_010 || o_remaining !== 31'd500 || o_done !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold%0d: got valid=%b sel=%b rem=%0d done=%b, expected 1 010 500 0",
                         k, o_coin_valid, o_coin_sel, o_remaining, o_done);
            end
            step();
        end
        i_coin_ready = 1'b1;
        step();
        tests++;
        if ({o_coin_valid, o_done} !== 2'b01 || o_remaining !== 31'd0) begin
            fails++;
            $display("FAIL stall_done: got valid=%b done=%b rem=%0d, expected 0 1 0",
                     o_coin_valid, o_done, o_remaining);
        end
        step();
    endtask

    task automatic test_250();
        i_coin_ready = 1'b1;
        send_req(250);
        tests++;
        if ({o_coin_valid, o_coin_sel} !== 4'b1_001 || o_remaining !== 31'd250) begin
            fails++;
            $display("FAIL r250_coin0: got valid=%b sel=%b rem=%0d, expected 1 001 250",
                     o_coin_valid, o_coin_sel, o_remaining);
        end
        step();
        tests++;
        if ({o_coin_valid, o_coin_sel} !== 4'b1_001 || o_remaining !== 31'd150) begin
            fails++;
            $display("FAIL r250_coin1: got valid=%b sel=%b rem=%0d, expected 1 001 150",
                     o_coin_valid, o_coin_sel, o_remaining);
        end
        step();
        tests++;
        if (o_done !== 1'b1 || o_coin_valid !== 1'b0 || o_remaining !== 31'd50) begin
            fails++;
            $display("FAIL r250_done: got done=%b valid=%b rem=%0d, expected 1 0 50",
                     o_done, o_coin_valid, o_remaining);
        end
        step(); step();
        tests++;
        if (o_busy !== 1'b0 || o_remaining !== 31'd50) begin
            fails++;
            $display("FAIL r250_residue: got busy=%b rem=%0d, expected 0 50", o_busy, o_remaining);
        end
    endtask

    task automatic test_reset_mid();
        i_coin_ready = 1'b1;
        send_req(3000);
        step();
        tests++;
        if (o_remaining !== 31'd2000 || o_coin_sel !== 3'b100) begin
            fails++;
            $display("FAIL mid_first: got rem=%0d sel=%b, expected 2000 100", o_remaining, o_coin_sel);
        end
        reset_n = 1'b0;
        #1;
        tests++;
        if ({o_coin_valid, o_coin_sel, o_busy, o_done, o_remaining} !== 37'd0) begin
            fails++;
            $display("FAIL mid_async: got valid=%b sel=%b busy=%b done=%b rem=%0d, expected all zero",
                     o_coin_valid, o_coin_sel, o_busy, o_done, o_remaining);
        end
        step();
        tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_nodone: got done=%b busy=%b, expected 0 0", o_done, o_busy);
        end
        reset_n = 1'b1;
        i_coin_ready = 1'b0;
        send_req(100);
        tests++;
        if ({o_coin_valid, o_coin_sel} !== 4'b1_001 || o_remaining !== 31'd100) begin
            fails++;
            $display("FAIL mid_first_req: got valid=%b sel=%b rem=%0d, expected 1 001 100",
                     o_coin_valid, o_coin_sel, o_remaining);
        end
        i_coin_ready = 1'b1;
        step(); step();
    endtask

    task automatic test_ignore_busy();
        int unsigned sum;
        int          done_cnt;
        sum = 0; done_cnt = 0;
        i_coin_ready = 1'b1;
        send_req(600);
        i_return_req    = 1'b1;
        i_return_amount = 31'd1000;
        for (int k = 0; k < 8; k++) begin
            if (o_coin_valid && i_coin_ready) sum += (o_coin_sel == 3'b100) ? 1000 :
                                                     (o_coin_sel == 3'b010) ? 500 :
                                                     (o_coin_sel == 3'b001) ? 100 : 0;
            if (o_done) begin
                done_cnt++;
                step();
                i_return_req = 1'b0;
                break;
            end
            step();
        end
        i_return_req = 1'b0;
        tests++;
        if (sum != 600 || done_cnt != 1 || o_busy !== 1'b0 || o_remaining !== 31'd0) begin
            fails++;
            $display("FAIL ignore_busy: got sum=%0d dones=%0d busy=%b rem=%0d, expected 600 1 0 0",
                     sum, done_cnt, o_busy, o_remaining);
        end
        step();
    endtask

    task automatic test_random();
        int unsigned amt;
        int unsigned mrem;
        int unsigned total;
        int unsigned q[$];
        logic [2:0]  exp_sel;
        bit          fin;
        reset_n = 1'b0; #1; reset_n = 1'b1;
        total = 0;
        for (int t = 0; t < 40; t++) begin
            amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 6000);
            q.delete();
            for (int n = 0; n < amt / 1000; n++) q.push_back(1000);
            for (int n = 0; n < (amt % 1000) / 500; n++) q.push_back(500);
            for (int n = 0; n < (amt % 500) / 100; n++) q.push_back(100);
            mrem = amt;
            i_coin_ready = 1'($urandom_range(0, 1));
            send_req(amt);
            fin = 1'b0;
            for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
                if (o_done) begin
                    fin = 1'b1;
                    tests++;
                    if (q.size() != 0 || o_coin_valid !== 1'b0 || o_remaining !== 31'(amt % 100)) begin
                        fails++;
                        $display("FAIL rand_done t%0d amt=%0d: got rem=%0d valid=%b left=%0d, expected rem=%0d valid=0 left=0",
                                 t, amt, o_remaining, o_coin_valid, q.size(), amt % 100);
                    end
                end else begin
                    exp_sel = (q.size() != 0) ? sel_of(q[0]) : 3'b000;
                    tests++;
                    if (o_coin_valid !== 1'b1 || o_coin_sel !== exp_sel || o_remaining !== 31'(mrem)) begin
                        fails++;
                        $display("FAIL rand_coin t%0d amt=%0d: got valid=%b sel=%b rem=%0d, expected 1 %b %0d",
                                 t, amt, o_coin_valid, o_coin_sel, o_remaining, exp_sel, mrem);
                    end
                    i_coin_ready = ($urandom_range(0, 3) != 0);
                    i_return_req    = ($urandom_range(0, 5) == 0);
                    i_return_amount = 31'($urandom_range(0, 9000));
                    if (o_coin_valid && i_coin_ready && q.size() != 0) begin
                        mrem  -= q[0];
                        total += q[0];
                        q.pop_front();
                    end
                end
                step();
            end
            i_return_req = 1'b0;
            if (!fin) begin
                tests++; fails++;
                $display("FAIL rand_timeout t%0d amt=%0d: got no done within 200 cycles, expected done", t, amt);
            end
        end
`ifdef CHANGE_DISPENSER_STATS_EN
        tests++;
        if (o_total_dispensed !== 31'(total)) begin
            fails++;
            $display("FAIL stats_total: got %0d, expected %0d", o_total_dispensed, total);
        end
`endif
    endtask

    initial begin
        tests = 0; fails = 0;
        test_reset();
        test_1600();
        test_zero();
        test_stall_500();
        test_250();
        test_reset_mid();
        test_ignore_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
